demux_1_to_n: RTL and testbench



---
 rtl/demux_pkg.sv | 10 +
 rtl/demux_1_to_n_onehot_decoder.sv | 18 +
 rtl/demux_1_to_n.sv | 36 +++
 tb/tb_demux_1_to_n.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and helpers for the demux_1_to_n family.
package demux_pkg;

   localparam int unsigned DEMUX_MAX_N = 8;

   function automatic int unsigned out_width(input int unsigned n);
      return 2 ** n;
   endfunction

endpackage

// File: rtl/demux_1_to_n_onehot_decoder.sv
// Select index to one-hot vector, gated by an enable.
module onehot_decoder
   import demux_pkg::*;
#(
   parameter int unsigned N = 3
) (
   input  logic [N-1:0]               s,
   input  logic                       en,
   output logic [out_width(N)-1:0]    y
);

   localparam int unsigned W = out_width(N);

   for (genvar i = 0; i < W; i++) begin : g_line
      assign y[i] = en & (s == N'(i));
   end

endmodule

// File: rtl/demux_1_to_n.sv
// 1-to-2^N one-bit demultiplexer with a combinational output and a registered copy.
module demux_1_to_n
   import demux_pkg::*;
#(
   parameter int unsigned N = 3
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       f,
   input  logic                       en,
   input  logic [N-1:0]               s,
   output logic [out_width(N)-1:0]    y,
   output logic [out_width(N)-1:0]    y_q
);

   if (N < 1 || N > DEMUX_MAX_N) begin : g_bad_n
      $error("demux_1_to_n: N=%0d outside 1..%0d", N, DEMUX_MAX_N);
   end

   onehot_decoder #(
      .N (N)
   ) u_dec (
      .s  (s),
      .en (en & f),
      .y  (y)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q <= '0;
      end else begin
         y_q <= y;
      end
   end

endmodule

// File: tb/tb_demux_1_to_n.sv
// Randomized self-checking bench for demux_1_to_n at N=1, 3 and 8.
module tb_demux_1_to_n;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         f;
   logic         en;
   logic [0:0]   s1;
   logic [2:0]   s3;
   logic [7:0]   s8;
   logic [1:0]   y1, y1_q;
   logic [7:0]   y3, y3_q;
   logic [255:0] y8, y8_q;

   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   demux_1_to_n #(.N(1)) u_dut1 (
      .clk (clk), .rst_n (rst_n), .f (f), .en (en), .s (s1), .y (y1), .y_q (y1_q)
   );
   demux_1_to_n #(.N(3)) u_dut3 (
      .clk (clk), .rst_n (rst_n), .f (f), .en (en), .s (s3), .y (y3), .y_q (y3_q)
   );
   demux_1_to_n #(.N(8)) u_dut8 (
      .clk (clk), .rst_n (rst_n), .f (f), .en (en), .s (s8), .y (y8), .y_q (y8_q)
   );

   // Reference: a single bit at position sel when both enable and data are high.
   function automatic logic [255:0] model_y(input bit e, input bit d, input int unsigned sel);
      logic [255:0] one;
      one = 256'd1;
      if (e && d) return one << sel;
      return '0;
   endfunction

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [255:0] want1, want3, want8;

   initial begin
      rst_n = 1'b0;
      f     = 1'b0;
      en    = 1'b0;
      s1    = '0;
      s3    = '0;
      s8    = '0;
      #2;
      check("reset_yq1", 256'(y1_q), '0);
      check("reset_yq3", 256'(y3_q), '0);
      check("reset_yq8", y8_q, '0);

      // Scenario 1: disabled, every select gives zero
      f  = 1'b1;
      en = 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
         s3 = 3'(i);
         #1;
         check("dis_y3", 256'(y3), model_y(0, 1, i));
      end

      // Scenario 2: enabled sweep, one-hot at s
      en = 1'b1;
      for (int unsigned i = 0; i < 8; i++) begin
         s3 = 3'(i);
         #1;
         check("en_y3", 256'(y3), model_y(1, 1, i));
         check("onehot3", 256'($countones(y3) == 1), 256'd1);
      end

      // Scenario 3: data low, then raise data with no clock edge
      @(negedge clk);
      f  = 1'b0;
      s3 = 3'd3;
      #1;
      check("f0_y3", 256'(y3), '0);
      f = 1'b1;
      #1;
      check("f1_y3", 256'(y3), 256'h08);
      check("held_yq3", 256'(y3_q), '0);

      // Release reset away from an edge, flush with enable low
      @(negedge clk);
      rst_n = 1'b1;
      en    = 1'b0;
      tick();
      check("flush_yq3", 256'(y3_q), '0);

      // Scenario 4: one cycle latency on y_q
      en = 1'b1;
      f  = 1'b1;
      s3 = 3'd2;
      #1;
      check("lat_before", 256'(y3_q), '0);
      tick();
      check("lat_edge_n", 256'(y3_q), 256'h04);
      #2;
      s3 = 3'd6;
      #1;
      check("lat_mid", 256'(y3_q), 256'h04);
      tick();
      check("lat_edge_n1", 256'(y3_q), 256'h40);

      // Scenario 5: asynchronous reset between edges
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_yq3", 256'(y3_q), '0);
      check("rst_y3", 256'(y3), 256'h40);
      tick();
      check("rst_hold_yq3", 256'(y3_q), '0);
      rst_n = 1'b1;
      #1;
      check("rel_before", 256'(y3_q), '0);
      tick();
      check("rel_reload", 256'(y3_q), 256'h40);

      // Scenario 6: N=1 and N=8 sweeps, including the end indices
      en = 1'b1;
      f  = 1'b1;
      for (int unsigned i = 0; i < 2; i++) begin
         s1 = 1'(i);
         #1;
         check("sweep_y1", 256'(y1), model_y(1, 1, i));
      end
      for (int unsigned i = 0; i < 24; i++) begin
         int unsigned sel;
         sel = (i == 0) ? 0 : (i == 1) ? 255 : $urandom_range(0, 255);
         s8  = 8'(sel);
         #1;
         check("sweep_y8", y8, model_y(1, 1, sel));
         check("onehot8", 256'($countones(y8) == 1), 256'd1);
      end

      // Random phase: combinational and registered outputs on all widths
      @(negedge clk);
      for (int unsigned n = 0; n < 200; n++) begin
         en = ($urandom_range(0, 3) != 0);
         f  = ($urandom_range(0, 3) != 0);
         s1 = 1'($urandom);
         s3 = 3'($urandom);
         s8 = 8'($urandom);
         #1;
         want1 = model_y(en, f, s1);
         want3 = model_y(en, f, s3);
         want8 = model_y(en, f, s8);
         check("rnd_y1", 256'(y1), want1);
         check("rnd_y3", 256'(y3), want3);
         check("rnd_y8", y8, want8);
         tick();
         check("rnd_yq1", 256'(y1_q), want1);
         check("rnd_yq3", 256'(y3_q), want3);
         check("rnd_yq8", y8_q, want8);
         #2;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
